// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, IEEE-754 single constants,
// fflags bit positions and the rounding unit's FSM states.
package fpu_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } rm_t;

  localparam logic [31:0] FP_CANON_NAN  = 32'h7FC00000;
  localparam logic [31:0] FP_POS_INF    = 32'h7F800000;
  localparam logic [30:0] FP_MAX_FINITE = 31'h7F7FFFFF;

  localparam int FL_NV = 4;
  localparam int FL_DZ = 3;
  localparam int FL_OF = 2;
  localparam int FL_UF = 1;
  localparam int FL_NX = 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROUND  = 2'd1,
    S_ADJUST = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/fpu_round_decide.sv
// Round-up decision from sign, mantissa lsb and guard/round/sticky bits.
// Purely combinational; reserved modes 101..111 fall back to RNE.
module fpu_round_decide
  import fpu_pkg::*;
(
  input  logic       sign,
  input  logic       lsb,
  input  logic       g,
  input  logic       r,
  input  logic       s,
  input  logic [2:0] rm,
  output logic       up,
  output logic       inexact
);

  // Select the increment for the requested rounding direction
  always_comb begin
    inexact = g | r | s;
    up      = g & (r | s | lsb);
    case (rm)
      RTZ:     up = 1'b0;
      RDN:     up = sign & inexact;
      RUP:     up = ~sign & inexact;
      RMM:     up = g;
      default: up = g & (r | s | lsb);
    endcase
  end

endmodule

// File: rtl/fpu_round.sv
// Rounding back end of the FP adder: turns the 35-bit unrounded bus into
// an IEEE-754 single word plus fflags over an IDLE->ROUND->ADJUST->DONE
// sequence (out_valid three cycles after new_input).
// Optional: define FPU_ROUND_FLAGS_EN to generate fflags; otherwise fflags
// is tied to zero and no flag logic is built.
module fpu_round
  import fpu_pkg::*;
#(
  parameter logic [31:0] CANON_NAN = FP_CANON_NAN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [34:0] in_val,
  input  logic [2:0]  rm,
  input  logic        new_input,
  output logic [31:0] out,
  output logic        out_valid,
  output logic        busy,
  output logic [4:0]  fflags
);

  state_t state, state_nxt;

  logic [34:0] in_p0;
  logic [2:0]  rm_p0;
  logic [30:0] sum_p1;
  logic [31:0] out_p2;
  logic [4:0]  fflags_p2;
  logic        vld_p2;

  logic        sign_p0;
  logic [7:0]  exp_p0;
  logic [22:0] mant_p0;
  logic        up_c;
  logic        inexact_c;
  logic [30:0] sum_c;
  logic        is_nan;
  logic        is_inf;
  logic        is_zero;
  logic        ovf;
  logic [31:0] out_c;
  logic [4:0]  flags_c;

  assign sign_p0 = in_p0[34];
  assign exp_p0  = in_p0[33:26];
  assign mant_p0 = in_p0[25:3];

  // Directed-rounding saturation: the value an overflowing result takes
  function automatic logic [31:0] sat_overflow(input logic sign, input logic [2:0] mode);
    case (mode)
      RTZ:     sat_overflow = {sign, FP_MAX_FINITE};
      RDN:     sat_overflow = sign ? {1'b1, FP_POS_INF[30:0]} : {1'b0, FP_MAX_FINITE};
      RUP:     sat_overflow = sign ? {1'b1, FP_MAX_FINITE} : {1'b0, FP_POS_INF[30:0]};
      default: sat_overflow = {sign, FP_POS_INF[30:0]};
    endcase
  endfunction

  fpu_round_decide u_decide (
    .sign    (sign_p0),
    .lsb     (in_p0[3]),
    .g       (in_p0[2]),
    .r       (in_p0[1]),
    .s       (in_p0[0]),
    .rm      (rm_p0),
    .up      (up_c),
    .inexact (inexact_c)
  );

  // Exp and mant form one monotone 31-bit magnitude, so a single add carries
  // mantissa overflow into the exponent and promotes subnormals to normals.
  assign sum_c = in_p0[33:3] + {30'd0, up_c};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state sequencing; new_input outside IDLE is dropped
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (new_input) state_nxt = S_ROUND;
      S_ROUND:  state_nxt = S_ADJUST;
      S_ADJUST: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign busy = ~rst & (new_input | (state == S_ROUND) | (state == S_ADJUST));

  // ---- stage 0: operand capture ----
  // Capture operand and mode on an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      in_p0 <= '0;
      rm_p0 <= '0;
    end else if (state == S_IDLE && new_input) begin
      in_p0 <= in_val;
      rm_p0 <= rm;
    end
  end

  // ---- stage 1: rounding increment ----
  // Hold the rounded magnitude for the adjust step
  always_ff @(posedge clk) begin
    if (rst)                    sum_p1 <= '0;
    else if (state == S_ROUND)  sum_p1 <= sum_c;
  end

  // ---- stage 2: special cases, overflow, output register ----
  assign is_nan  = (exp_p0 == 8'hFF) && (mant_p0 != 23'd0);
  assign is_inf  = (exp_p0 == 8'hFF) && (mant_p0 == 23'd0);
  assign is_zero = (exp_p0 == 8'h00) && (mant_p0 == 23'd0) && (in_p0[2:0] == 3'b000);
  assign ovf     = (exp_p0 != 8'hFF) && (sum_p1[30:23] == 8'hFF);

  // Final word selection; specials take precedence over the rounded value
  always_comb begin
    out_c = {sign_p0, sum_p1};
    if (is_nan)       out_c = CANON_NAN;
    else if (is_inf)  out_c = {sign_p0, 8'hFF, 23'd0};
    else if (is_zero) out_c = {sign_p0, 31'd0};
    else if (ovf)     out_c = sat_overflow(sign_p0, rm_p0);
  end

`ifdef FPU_ROUND_FLAGS_EN
  logic inexact_p1;

  // Keep the inexact indication alongside the rounded magnitude
  always_ff @(posedge clk) begin
    if (rst)                    inexact_p1 <= 1'b0;
    else if (state == S_ROUND)  inexact_p1 <= inexact_c;
  end

  // Exception flags; underflow uses tininess after rounding
  always_comb begin
    flags_c = '0;
    if (!(is_nan || is_inf || is_zero)) begin
      flags_c[FL_OF] = ovf;
      flags_c[FL_NX] = inexact_p1 | ovf;
      flags_c[FL_UF] = (inexact_p1 | ovf) && (sum_p1[30:23] == 8'h00);
    end
  end
`else
  logic unused_inexact;
  assign unused_inexact = inexact_c;
  assign flags_c = '0;
`endif

  // Result registers; they hold until the next adjust step
  always_ff @(posedge clk) begin
    if (rst) begin
      out_p2    <= '0;
      fflags_p2 <= '0;
      vld_p2    <= 1'b0;
    end else begin
      vld_p2 <= (state == S_ADJUST);
      if (state == S_ADJUST) begin
        out_p2    <= out_c;
        fflags_p2 <= flags_c;
      end
    end
  end

  assign out       = out_p2;
  assign fflags    = fflags_p2;
  assign out_valid = vld_p2;

endmodule

// File: tb/tb_fpu_round.sv
// Self-checking bench for fpu_round: directed vectors, randomized operands
// against an arithmetic reference model, reset and handshake corner cases.
module tb_fpu_round;

  logic        clk = 1'b0;
  logic        rst;
  logic [34:0] in_val;
  logic [2:0]  rm;
  logic        new_input;
  logic [31:0] out;
  logic        out_valid;
  logic        busy;
  logic [4:0]  fflags;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fpu_round dut (
    .clk       (clk),
    .rst       (rst),
    .in_val    (in_val),
    .rm        (rm),
    .new_input (new_input),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy),
    .fflags    (fflags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: magnitude as an integer plus a fraction in eighths of an ulp
  function automatic void model(input logic [34:0] v, input logic [2:0] m,
                                output logic [31:0] r, output logic [4:0] f);
    logic     sign;
    longint   mag;
    longint   res;
    int       frac;
    bit       up;
    bit       ovf;
    bit       nx;
    sign = v[34];
    mag  = longint'(v[33:3]);
    frac = int'(v[2:0]);
    f    = 5'd0;
    if (v[33:26] == 8'hFF) begin
      r = (v[25:3] != 23'd0) ? 32'h7FC00000 : {sign, 8'hFF, 23'd0};
      return;
    end
    case (m)
      3'd1:    up = 1'b0;
      3'd2:    up = sign && frac > 0;
      3'd3:    up = !sign && frac > 0;
      3'd4:    up = frac >= 4;
      default: up = frac > 4 || (frac == 4 && (mag % 2) == 1);
    endcase
    res = mag + (up ? 1 : 0);
    ovf = res >= 64'h7F800000;
    nx  = (frac != 0) || ovf;
    if (ovf) begin
      case (m)
        3'd1:    r = {sign, 31'h7F7FFFFF};
        3'd2:    r = sign ? 32'hFF800000 : 32'h7F7FFFFF;
        3'd3:    r = sign ? 32'hFF7FFFFF : 32'h7F800000;
        default: r = {sign, 31'h7F800000};
      endcase
    end else begin
      r = {sign, res[30:0]};
    end
    f = {2'b00, ovf, nx && (res < 64'h800000), nx};
`ifndef FPU_ROUND_FLAGS_EN
    f = 5'd0;
`endif
  endfunction

  // One full transaction starting on a negedge; checks latency, busy, result
  task automatic run_op(input logic [34:0] v, input logic [2:0] m, input string tag);
    logic [31:0] er;
    logic [4:0]  ef;
    int          lat;
    model(v, m, er, ef);
    in_val    = v;
    rm        = m;
    new_input = 1'b1;
    #1;
    check({tag, " busy_start"}, 32'(busy), 32'd1);
    @(negedge clk);
    new_input = 1'b0;
    in_val    = 35'($urandom);
    rm        = 3'($urandom_range(0, 7));
    lat = 1;
    while (!out_valid && lat < 10) begin
      check({tag, " busy_mid"}, 32'(busy), 32'd1);
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd3);
    check({tag, " out"}, out, er);
    check({tag, " fflags"}, 32'(fflags), 32'(ef));
    check({tag, " busy_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, " valid_pulse"}, 32'(out_valid), 32'd0);
    check({tag, " out_hold"}, out, er);
  endtask

  logic [34:0] dir_v [14];
  logic [2:0]  dir_m [14];

  initial begin
    logic [31:0] ea;
    logic [4:0]  fa;
    logic [31:0] got;
    int          pulses;
    logic [7:0]  e;
    logic [22:0] mt;

    rst = 1'b1; new_input = 1'b0; in_val = '0; rm = '0;
    repeat (3) @(negedge clk);
    check("reset out", out, 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset fflags", 32'(fflags), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    dir_v[0]  = {1'b0, 8'h7F, 23'h000000, 3'b100}; dir_m[0]  = 3'd0;
    dir_v[1]  = {1'b0, 8'h7F, 23'h000000, 3'b100}; dir_m[1]  = 3'd3;
    dir_v[2]  = {1'b0, 8'h7F, 23'h7FFFFF, 3'b110}; dir_m[2]  = 3'd0;
    dir_v[3]  = {1'b0, 8'hFE, 23'h7FFFFF, 3'b100}; dir_m[3]  = 3'd0;
    dir_v[4]  = {1'b0, 8'hFE, 23'h7FFFFF, 3'b100}; dir_m[4]  = 3'd1;
    dir_v[5]  = {1'b1, 8'hFE, 23'h7FFFFF, 3'b100}; dir_m[5]  = 3'd3;
    dir_v[6]  = {1'b1, 8'hFE, 23'h7FFFFF, 3'b100}; dir_m[6]  = 3'd2;
    dir_v[7]  = {1'b1, 8'h00, 23'h7FFFFF, 3'b111}; dir_m[7]  = 3'd2;
    dir_v[8]  = {1'b0, 8'h00, 23'h000001, 3'b100}; dir_m[8]  = 3'd0;
    dir_v[9]  = {1'b0, 8'hFF, 23'h000001, 3'b000}; dir_m[9]  = 3'd0;
    dir_v[10] = {1'b1, 8'hFF, 23'h000000, 3'b101}; dir_m[10] = 3'd0;
    dir_v[11] = {1'b1, 8'h00, 23'h000000, 3'b000}; dir_m[11] = 3'd0;
    dir_v[12] = {1'b0, 8'h80, 23'h000001, 3'b100}; dir_m[12] = 3'd6;
    dir_v[13] = {1'b1, 8'hFE, 23'h7FFFFF, 3'b100}; dir_m[13] = 3'd4;
    for (int i = 0; i < 14; i++) run_op(dir_v[i], dir_m[i], $sformatf("dir%0d", i));

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       e = 8'h00;
        1:       e = 8'hFE;
        2:       e = 8'hFF;
        default: e = 8'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       mt = 23'h7FFFFF;
        1:       mt = 23'h000000;
        default: mt = 23'($urandom);
      endcase
      run_op({1'($urandom), e, mt, 3'($urandom)}, 3'($urandom_range(0, 7)),
             $sformatf("rnd%0d", i));
    end

    // Reset while in ROUND: unit returns idle, result registers clear, no pulse
    in_val = {1'b0, 8'h7F, 23'h1, 3'b111}; rm = 3'd3; new_input = 1'b1;
    @(negedge clk);
    new_input = 1'b0;
    rst = 1'b1;
    #1;
    check("rst busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst idle_busy", 32'(busy), 32'd0);
    check("rst out_clear", out, 32'd0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("rst no_valid", 32'(pulses), 32'd0);

    // Second start one cycle later and a start during DONE are both dropped
    model({1'b0, 8'h85, 23'h12345, 3'b011}, 3'd4, ea, fa);
    in_val = {1'b0, 8'h85, 23'h12345, 3'b011}; rm = 3'd4; new_input = 1'b1;
    @(negedge clk);
    in_val = {1'b1, 8'h20, 23'h54321, 3'b100}; rm = 3'd0;
    @(negedge clk);
    new_input = 1'b0;
    pulses = 0; got = '0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) begin
        pulses++;
        got = out;
        new_input = 1'b1;
        in_val = {1'b0, 8'h40, 23'h7, 3'b100};
      end else begin
        new_input = 1'b0;
      end
      @(negedge clk);
    end
    new_input = 1'b0;
    check("overlap pulses", 32'(pulses), 32'd1);
    check("overlap out", got, ea);
    check("overlap fflags", 32'(fflags), 32'(fa));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
